// File: rtl/dual_issue_fetch_pkg.sv
// Shared decode constants and FSM encoding for the dual-issue fetch/pairing stage.
// The optional DUAL_ISSUE_MEM_SPLIT_EN macro is consumed by pair_hazard_check.
package dual_issue_fetch_pkg;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_JAL   = 6'd3;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_BNE   = 6'd5;
    localparam logic [5:0] OP_ADDI  = 6'd8;
    localparam logic [5:0] OP_ADDIU = 6'd9;
    localparam logic [5:0] OP_SLTI  = 6'd10;
    localparam logic [5:0] OP_ANDI  = 6'd12;
    localparam logic [5:0] OP_ORI   = 6'd13;
    localparam logic [5:0] OP_LUI   = 6'd15;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;

    localparam logic [5:0] FUNCT_JR = 6'd8;

    typedef enum logic {
        PAIR   = 1'b0,
        SECOND = 1'b1
    } state_t;

    function automatic logic is_mem_op(input logic [5:0] op);
        return (op == OP_LW) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/dual_issue_fetch_if.sv
// Bus between the fetch/pairing stage and its surroundings: instruction memory,
// the two execution pipes and the execute-stage redirect/stall controls.
interface dual_issue_fetch_if;

    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] a_fetch_instr;
    logic [31:0] b_fetch_instr;
    logic [31:0] a_pc;
    logic [31:0] b_pc;
    logic [31:0] a_issue_instr;
    logic        a_issue_valid;
    logic [31:0] b_issue_instr;
    logic        b_issue_valid;
    logic        split;

    modport master (
        input  stall, redirect_valid, redirect_pc, a_fetch_instr, b_fetch_instr,
        output a_pc, b_pc, a_issue_instr, a_issue_valid, b_issue_instr, b_issue_valid, split
    );

    modport slave (
        output stall, redirect_valid, redirect_pc, a_fetch_instr, b_fetch_instr,
        input  a_pc, b_pc, a_issue_instr, a_issue_valid, b_issue_instr, b_issue_valid, split
    );

endinterface

// File: rtl/dual_issue_fetch_pair_hazard_check.sv
// Combinational pairing check: does instruction B depend on A, or is A control flow?
// With DUAL_ISSUE_MEM_SPLIT_EN defined, two memory ops also count as a conflict.
module pair_hazard_check
    import dual_issue_fetch_pkg::*;
(
    input  logic [31:0] a_instr,
    input  logic [31:0] b_instr,
    output logic        conflict
);

    logic [5:0] a_op_s;
    logic [5:0] b_op_s;
    logic [4:0] a_dest_s;
    logic       a_has_dest_s;
    logic       b_rt_src_s;
    logic       a_ctrl_s;
    logic       mem_pair_s;

    assign a_op_s = a_instr[31:26];
    assign b_op_s = b_instr[31:26];

    // Destination register written by A; $0 writes are architecturally dead.
    always_comb begin
        a_dest_s     = 5'd0;
        a_has_dest_s = 1'b0;
        case (a_op_s)
            OP_RTYPE: begin
                a_dest_s     = a_instr[15:11];
                a_has_dest_s = (a_instr[15:11] != 5'd0);
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_ANDI, OP_ORI, OP_LUI, OP_LW: begin
                a_dest_s     = a_instr[20:16];
                a_has_dest_s = (a_instr[20:16] != 5'd0);
            end
            default: begin
                a_dest_s     = 5'd0;
                a_has_dest_s = 1'b0;
            end
        endcase
    end

    // Whether B reads rt in addition to rs.
    always_comb begin
        b_rt_src_s = 1'b0;
        case (b_op_s)
            OP_RTYPE, OP_BEQ, OP_BNE, OP_SW: b_rt_src_s = 1'b1;
            default:                         b_rt_src_s = 1'b0;
        endcase
    end

    // Control-flow classification of A.
    always_comb begin
        a_ctrl_s = 1'b0;
        case (a_op_s)
            OP_J, OP_JAL, OP_BEQ, OP_BNE: a_ctrl_s = 1'b1;
            OP_RTYPE:                     a_ctrl_s = (a_instr[5:0] == FUNCT_JR);
            default:                      a_ctrl_s = 1'b0;
        endcase
    end

`ifdef DUAL_ISSUE_MEM_SPLIT_EN
    assign mem_pair_s = is_mem_op(a_op_s) && is_mem_op(b_op_s);
`else
    assign mem_pair_s = 1'b0;
`endif

    assign conflict = a_ctrl_s
                   || mem_pair_s
                   || (a_has_dest_s && (a_dest_s == b_instr[25:21]))
                   || (a_has_dest_s && b_rt_src_s && (a_dest_s == b_instr[20:16]));

endmodule

// File: rtl/dual_issue_fetch.sv
// Dual-issue fetch and pairing stage: owns the fetch PC and issues the pair at
// pc/pc+4 together, or over two cycles on conflict (see pair_hazard_check).
module dual_issue_fetch
    import dual_issue_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    dual_issue_fetch_if.master    bus
);

    state_t      state_r;
    logic [31:0] pc_r;
    logic [31:0] a_instr_r;
    logic [31:0] b_instr_r;
    logic        a_valid_r;
    logic        b_valid_r;
    logic        conflict_s;

    pair_hazard_check u_hazard (
        .a_instr  (bus.a_fetch_instr),
        .b_instr  (bus.b_fetch_instr),
        .conflict (conflict_s)
    );

    // Fetch PC, pairing FSM and issue registers; priority rst > redirect > stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_r      <= RESET_PC;
            state_r   <= PAIR;
            a_instr_r <= 32'd0;
            b_instr_r <= 32'd0;
            a_valid_r <= 1'b0;
            b_valid_r <= 1'b0;
        end else if (bus.redirect_valid) begin
            pc_r      <= {bus.redirect_pc[31:2], 2'b00};
            state_r   <= PAIR;
            a_valid_r <= 1'b0;
            b_valid_r <= 1'b0;
        end else if (!bus.stall) begin
            case (state_r)
                PAIR: begin
                    a_instr_r <= bus.a_fetch_instr;
                    a_valid_r <= 1'b1;
                    if (conflict_s) begin
                        b_valid_r <= 1'b0;
                        state_r   <= SECOND;
                    end else begin
                        b_instr_r <= bus.b_fetch_instr;
                        b_valid_r <= 1'b1;
                        pc_r      <= pc_r + 32'd8;
                    end
                end
                SECOND: begin
                    b_instr_r <= bus.b_fetch_instr;
                    b_valid_r <= 1'b1;
                    a_valid_r <= 1'b0;
                    pc_r      <= pc_r + 32'd8;
                    state_r   <= PAIR;
                end
                default: begin
                    state_r   <= PAIR;
                    a_valid_r <= 1'b0;
                    b_valid_r <= 1'b0;
                end
            endcase
        end else begin
            state_r <= state_r;
        end
    end

    assign bus.a_pc          = pc_r;
    assign bus.b_pc          = pc_r + 32'd4;
    assign bus.a_issue_instr = a_instr_r;
    assign bus.b_issue_instr = b_instr_r;
    assign bus.a_issue_valid = a_valid_r;
    assign bus.b_issue_valid = b_valid_r;
    assign bus.split         = (state_r == SECOND);

endmodule

// File: doc/dual_issue_fetch.md
Name: dual_issue_fetch

Overview:
- Fetch and pairing stage for the dual-pipe MIPS core; it sits directly upstream of the instruction memory and the two execution pipes.
- Owns the fetch PC. The instruction memory returns the instruction at pc (slot a) and the one at pc+4 (slot b) in the same cycle.
- The block checks whether the two can issue together. It registers the issued pair toward pipes a and b, or splits the pair across two cycles when they conflict.

Parameters:
- RESET_PC, 32'h0000_0000, fetch address loaded on reset.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; synchronous, active-high.
- stall  in  1  downstream hold; freezes all state.
- redirect_valid  in  1  taken branch or jump from execute.
- redirect_pc  in  32  new fetch address; bits [1:0] ignored, forced to 0.
- a_fetch_instr  in  32  instruction memory data at pc.
- b_fetch_instr  in  32  instruction memory data at pc+4.
- a_pc  out  32  fetch address driven to instruction memory.
- b_pc  out  32  a_pc+4, combinational, modulo 2^32.
- a_issue_instr  out  32  registered instruction for pipe a.
- a_issue_valid  out  1  pipe a slot valid.
- b_issue_instr  out  32  registered instruction for pipe b.
- b_issue_valid  out  1  pipe b slot valid.
- split  out  1  high while in state SECOND.

Behaviour:
- Instruction memory read is combinational. Issue outputs are registered, so issue latency is 1 cycle from a_pc.
- Reset (rst=1 at a clk edge):
  - a_pc=RESET_PC, state=PAIR.
  - both issue_valid=0; both issue_instr=0; split=0.
  - Reset overrides redirect and stall, including mid-split.
- Decode, applied to a_fetch_instr (A) and b_fetch_instr (B):
  - dest(A): rd[15:11] if op=0; rt[20:16] if op is one of 8,9,10,12,13,15,35; otherwise none. Register 0 never counts as a dest.
  - srcs(B): rs[25:21] always. rt[20:16] is also a source if op is one of 0,4,5,43.
  - A is control if op is one of 2,3,4,5, or if op=0 with funct=8 (jr).
  - conflict = (dest(A) is a source of B) OR (A is control).
- Priority per edge: rst > redirect_valid > stall > normal.
- redirect_valid=1:
  - a_pc<=redirect_pc & ~3; state<=PAIR; both valid<=0.
  - Applies even when stall=1 and even in SECOND; a pending B is discarded.
- stall=1 with no redirect: every register holds.
- Normal operation in PAIR:
  - No conflict: a_issue<=A, b_issue<=B, both valid<=1, a_pc<=a_pc+8.
  - Conflict: a_issue<=A with a_valid<=1; b_valid<=0; a_pc holds; state<=SECOND.
- Normal operation in SECOND:
  - b_issue<=B, b_valid<=1, a_valid<=0, a_pc<=a_pc+8, state<=PAIR.
  - No second conflict check is made.
- a_issue_instr and b_issue_instr hold their previous value while the matching valid is 0.
- PC arithmetic is 32-bit and wraps from 32'hFFFF_FFF8 to 0.
- States: PAIR (0), SECOND (1); split = (state==SECOND).

Optional Feature:
- Macro DUAL_ISSUE_MEM_SPLIT_EN.
- Defined: conflict additionally includes the case where both A and B are memory ops (op 35 or 43). This prevents same-cycle dual data-memory access.
- Undefined: memory pairs issue together and data memory resolves simultaneous accesses.

Decomposition:
- Shared package holds:
  - opcode constants: OP_RTYPE=0, OP_J=2, OP_JAL=3, OP_BEQ=4, OP_BNE=5, OP_ADDI=8, OP_LW=35, OP_SW=43, and the other I-type opcodes listed above;
  - FUNCT_JR=8;
  - state encoding PAIR/SECOND.
- One natural sub-module, pair_hazard_check: combinational decode of A/B producing conflict. It is reusable by later issue logic.

Test Plan:
- Reset, then release with A=addi $1,$0,5, B=addi $2,$0,7 -> a_pc 0,8,16; after the first edge both valid=1 and issue_instr match.
- A=addi $3,$0,1, B=add $4,$3,$3 -> cycle 1: a_valid=1, b_valid=0, split=1, a_pc holds 0; cycle 2: b_valid=1, a_valid=0, a_pc=8.
- A=beq $0,$0,off, redirect_valid=1 to 0x40 during SECOND -> a_pc=0x40, both valid=0, split=0; B is never issued.
- stall=1 for 3 cycles mid-stream -> a_pc, valids, instrs and state are unchanged; the stream resumes exactly.
- a_pc=32'hFFFF_FFF8 with a non-conflicting pair -> a_pc=0 next cycle, b_pc=4.
- A=lw $5,0($0), B=sw $6,4($0) -> with DUAL_ISSUE_MEM_SPLIT_EN: split over 2 cycles; without: issued together.
